coin_charge_ctrl: RTL and testbench

- Front-end controller for the charger. Detects coin insertions, converts them to a charging-time credit in seconds, and drives the Timer's `start` input.
- Consumes the Timer's one-second `timing` ticks to count the credit down.
- Gates the charging relay (`charge_en`) and exports the remaining seconds for the display.
- Sits between the coin acceptor and Timer: the initiator/consumer end of the Timer start/timing interface.

---
 rtl/coin_charge_ctrl.sv | 106 ++++++++++
 tb/tb_coin_charge_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/coin_charge_ctrl.sv
// Coin-operated charging front end: turns coin insertions into seconds of credit,
// drives the Timer start line and counts the credit down on its one-second ticks.
module coin_charge_ctrl #(
    parameter int unsigned SEC_PER_UNIT = 60,
    parameter int unsigned MAX_CREDIT   = 1800,
    parameter int unsigned CREDIT_W     = 11
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          coin_in,
    input  logic                cancel,
    input  logic                timing,
    output logic                start,
    output logic                charge_en,
    output logic [CREDIT_W-1:0] remaining,
    output logic                full,
    output logic                done
);

    localparam int unsigned SUM_W = CREDIT_W + 4;
    localparam logic [SUM_W-1:0]    MAX_S = SUM_W'(MAX_CREDIT);
    localparam logic [CREDIT_W-1:0] MAX_C = CREDIT_W'(MAX_CREDIT);

    typedef enum logic {
        IDLE,
        CHARGING
    } state_e;

    state_e              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [1:0]          coin_prev_q;
    logic                done_d;

    logic [1:0]          ev;
    logic [2:0]          units;
    logic                dec;
    logic [SUM_W-1:0]    add;
    logic [SUM_W-1:0]    sum;
    logic [SUM_W-1:0]    capped;

    // Edge-detect coins, form the saturated next credit and the next state.
    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        done_d   = 1'b0;

        ev    = coin_in & ~coin_prev_q;
        units = 3'(ev[0]) + (ev[1] ? 3'd5 : 3'd0);
        add   = SUM_W'(units) * SUM_W'(SEC_PER_UNIT);
        dec   = (state_q == CHARGING) && timing;

        // A coin landing on the final tick restarts the credit from add - 1.
        if (credit_q == CREDIT_W'(1) && dec && (|ev)) begin
            sum = add - SUM_W'(1);
        end else begin
            sum = SUM_W'(credit_q) + add - SUM_W'(dec);
        end
        capped = (sum > MAX_S) ? MAX_S : sum;

        case (state_q)
            IDLE: begin
                if (!cancel && (|ev)) begin
                    credit_d = CREDIT_W'(capped);
                    state_d  = CHARGING;
                end
            end
            CHARGING: begin
                if (cancel) begin
                    credit_d = '0;
                    state_d  = IDLE;
                end else begin
                    credit_d = CREDIT_W'(capped);
                    if (capped == '0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, credit, coin history and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            credit_q    <= '0;
            coin_prev_q <= '0;
            start       <= 1'b0;
            charge_en   <= 1'b0;
            remaining   <= '0;
            full        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_q     <= state_d;
            credit_q    <= credit_d;
            coin_prev_q <= coin_in;
            start       <= (state_d == CHARGING);
            charge_en   <= (state_d == CHARGING);
            remaining   <= credit_d;
            full        <= (credit_d == MAX_C);
            done        <= done_d;
        end
    end

endmodule

// File: tb/tb_coin_charge_ctrl.sv
// Bench for coin_charge_ctrl: directed scenarios with literal expectations, then
// random coins/cancels/ticks/resets checked every cycle against an integer model.
module tb_coin_charge_ctrl;

    localparam int unsigned SEC = 2;
    localparam int unsigned MAX = 20;
    localparam int unsigned W   = 5;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [1:0]   coin_in = 2'b00;
    logic         cancel = 1'b0;
    logic         timing = 1'b0;
    logic         start;
    logic         charge_en;
    logic [W-1:0] remaining;
    logic         full;
    logic         done;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Reference model state
    int       m_credit = 0;
    bit       m_chg    = 1'b0;
    bit       m_done   = 1'b0;
    bit [1:0] m_prev   = 2'b00;

    coin_charge_ctrl #(
        .SEC_PER_UNIT(SEC),
        .MAX_CREDIT  (MAX),
        .CREDIT_W    (W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .coin_in  (coin_in),
        .cancel   (cancel),
        .timing   (timing),
        .start    (start),
        .charge_en(charge_en),
        .remaining(remaining),
        .full     (full),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: credit in whole seconds, a charging flag and the previous coin levels.
    always @(posedge clk or posedge reset) begin : model
        int units;
        int add;
        int t;
        bit tick;
        if (reset) begin
            m_credit <= 0;
            m_chg    <= 1'b0;
            m_done   <= 1'b0;
            m_prev   <= 2'b00;
        end else begin
            units = 0;
            if (coin_in[0] && !m_prev[0]) units = units + 1;
            if (coin_in[1] && !m_prev[1]) units = units + 5;
            add  = units * SEC;
            tick = m_chg && timing;
            m_done <= 1'b0;
            if (cancel) begin
                m_credit <= 0;
                m_chg    <= 1'b0;
            end else if (!m_chg) begin
                if (units > 0) begin
                    m_credit <= (add > MAX) ? MAX : add;
                    m_chg    <= 1'b1;
                end
            end else begin
                if (m_credit == 1 && tick && units > 0) t = add - 1;
                else t = m_credit + add - (tick ? 1 : 0);
                if (t > MAX) t = MAX;
                m_credit <= t;
                if (t == 0) begin
                    m_chg  <= 1'b0;
                    m_done <= 1'b1;
                end
            end
            m_prev <= coin_in;
        end
    end

    // Compare DUT against the model on every falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("start",     int'(start),     int'(m_chg));
            chk("charge_en", int'(charge_en), int'(m_chg));
            chk("remaining", int'(remaining), m_credit);
            chk("full",      int'(full),      (m_credit == MAX) ? 1 : 0);
            chk("done",      int'(done),      int'(m_done));
        end
    end

    // Apply one cycle of inputs; returns 1 time unit after the clock edge.
    task automatic cyc(input logic [1:0] c, input logic can, input logic tm);
        coin_in = c;
        cancel  = can;
        timing  = tm;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2 reset = 1'b1;
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_start",  int'(start), 0);
        chk("rst_chg_en", int'(charge_en), 0);
        chk("rst_remain", int'(remaining), 0);
        chk("rst_full",   int'(full), 0);
        chk("rst_done",   int'(done), 0);
        reset = 1'b0;

        // Held 1-unit coin counts once; two ticks expire it.
        cyc(2'b01, 1'b0, 1'b0);
        chk("coin1_remain", int'(remaining), 2);
        chk("coin1_start",  int'(start), 1);
        chk("coin1_chg_en", int'(charge_en), 1);
        repeat (9) cyc(2'b01, 1'b0, 1'b0);
        chk("held_remain", int'(remaining), 2);
        cyc(2'b01, 1'b0, 1'b1);
        chk("tick1_remain", int'(remaining), 1);
        cyc(2'b00, 1'b0, 1'b1);
        chk("expire_remain", int'(remaining), 0);
        chk("expire_start",  int'(start), 0);
        chk("expire_done",   int'(done), 1);
        cyc(2'b00, 1'b0, 1'b0);
        chk("done_one_cycle", int'(done), 0);

        // Both coins at once, then coin + tick saturating.
        cyc(2'b11, 1'b0, 1'b0);
        chk("both_remain", int'(remaining), 12);
        cyc(2'b00, 1'b0, 1'b0);
        cyc(2'b10, 1'b0, 1'b1);
        chk("sat_remain", int'(remaining), 20);
        chk("sat_full",   int'(full), 1);
        cyc(2'b00, 1'b0, 1'b1);
        chk("unsat_remain", int'(remaining), 19);
        chk("unsat_full",   int'(full), 0);

        // From 18, two 5-unit coins stick at the ceiling.
        cyc(2'b00, 1'b0, 1'b1);
        chk("at18", int'(remaining), 18);
        cyc(2'b10, 1'b0, 1'b0);
        cyc(2'b00, 1'b0, 1'b0);
        cyc(2'b10, 1'b0, 1'b0);
        chk("stick_remain", int'(remaining), 20);
        chk("stick_full",   int'(full), 1);

        // Cancel beats coin and tick.
        cyc(2'b00, 1'b0, 1'b0);
        repeat (13) cyc(2'b00, 1'b0, 1'b1);
        chk("at7", int'(remaining), 7);
        cyc(2'b01, 1'b1, 1'b1);
        chk("cancel_remain", int'(remaining), 0);
        chk("cancel_start",  int'(start), 0);
        chk("cancel_done",   int'(done), 0);

        // Coin on the final tick keeps charging without done.
        cyc(2'b00, 1'b0, 1'b0);
        cyc(2'b01, 1'b0, 1'b0);
        cyc(2'b00, 1'b0, 1'b1);
        chk("at1", int'(remaining), 1);
        cyc(2'b01, 1'b0, 1'b1);
        chk("last_coin_remain", int'(remaining), 1);
        chk("last_coin_start",  int'(start), 1);
        chk("last_coin_done",   int'(done), 0);

        // Asynchronous reset between edges.
        #3 reset = 1'b1;
        #1;
        chk("async_start",  int'(start), 0);
        chk("async_chg_en", int'(charge_en), 0);
        chk("async_remain", int'(remaining), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) cyc(2'b00, 1'b0, 1'b1);
        chk("idle_tick_remain", int'(remaining), 0);
        chk("idle_tick_start",  int'(start), 0);

        // Randomized traffic; the compare process does the checking.
        for (int i = 0; i < 3000; i++) begin
            logic [1:0] c;
            c = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 2) != 0) c = coin_in & c;
            if ($urandom_range(0, 299) == 0) begin
                reset = 1'b1;
                cyc(c, 1'b0, 1'b0);
                reset = 1'b0;
            end else begin
                cyc(c, ($urandom_range(0, 39) == 0), ($urandom_range(0, 2) == 0));
            end
        end
        cyc(2'b00, 1'b0, 1'b0);
        @(negedge clk);
        chk_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
